// File: rtl/seq_const_mul.sv
// rtl/seq_const_mul.sv - iterative shift-add multiplier p = a*k + cin with valid/ready handshakes
module seq_const_mul #(
  parameter  int IN_W  = 6,
  parameter  int K_W   = 4,
  localparam int OUT_W = IN_W + K_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_a,
  input  logic [K_W-1:0]   i_k,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_p,
  output logic             o_busy
);

  localparam int             CNT_W = $clog2(K_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] a_reg;
  logic [K_W-1:0]   k_reg;
  logic [CNT_W-1:0] cnt;

  // acc is only written in IDLE (seed with cin) and RUN; it holds stable through DONE
  assign o_p = acc;

  // Control FSM and datapath: one multiplier bit consumed per RUN cycle, flags registered with the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      a_reg   <= '0;
      k_reg   <= '0;
      cnt     <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg   <= OUT_W'(i_a);
            k_reg   <= i_k;
            acc     <= OUT_W'(i_cin);
            cnt     <= '0;
            state   <= RUN;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        RUN: begin
          // fixed K_W iterations; zero multiplier bits still cost a cycle
          if (k_reg[0]) begin
            acc <= acc + a_reg;
          end
          a_reg <= a_reg << 1;
          k_reg <= k_reg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_const_mul.sv
// tb/tb_seq_const_mul.sv - scoreboard bench for seq_const_mul, default and 8x8 instances
module tb_seq_const_mul;

  localparam int IN_W  = 6;
  localparam int K_W   = 4;
  localparam int OUT_W = IN_W + K_W;
  localparam int IN_W8  = 8;
  localparam int K_W8   = 8;
  localparam int OUT_W8 = IN_W8 + K_W8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready;
  logic [IN_W-1:0]   a = '0;
  logic [K_W-1:0]    k = '0;
  logic              cin = 1'b0;
  logic              out_valid;
  logic              ready = 1'b1;
  logic [OUT_W-1:0]  p;
  logic              busy;

  logic              in_valid8 = 1'b0;
  logic              out_ready8;
  logic [IN_W8-1:0]  a8 = '0;
  logic [K_W8-1:0]   k8 = '0;
  logic              cin8 = 1'b0;
  logic              out_valid8;
  logic              ready8 = 1'b1;
  logic [OUT_W8-1:0] p8;
  logic              busy8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_q[$];
  int acc_q[$];
  int exp8_q[$];
  int acc8_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_const_mul #(.IN_W(IN_W), .K_W(K_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
    .i_a(a), .i_k(k), .i_cin(cin), .o_valid(out_valid), .i_ready(ready),
    .o_p(p), .o_busy(busy)
  );

  seq_const_mul #(.IN_W(IN_W8), .K_W(K_W8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid8), .o_ready(out_ready8),
    .i_a(a8), .i_k(k8), .i_cin(cin8), .o_valid(out_valid8), .i_ready(ready8),
    .o_p(p8), .o_busy(busy8)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor for the default instance: pops expected results, checks latency, hold and release
  logic             prev_valid = 1'b0;
  logic             prev_hs = 1'b0;
  logic             prev_stall = 1'b0;
  int               held_p = 0;
  always @(negedge clk) begin
    if (prev_hs) begin
      check("ready_after_handshake", int'(out_ready), 1);
      check("valid_drop_after_handshake", int'(out_valid), 0);
    end
    if (prev_stall) begin
      check("valid_held_under_backpressure", int'(out_valid), 1);
      check("p_held_under_backpressure", int'(p), held_p);
    end
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_result");
      else check("result", int'(p), exp_q.pop_front());
      if (acc_q.size() == 0) fail_now("result_without_accept");
      else check("latency", cyc - acc_q.pop_front(), K_W);
      held_p = int'(p);
    end
    if (out_ready && in_valid && !rst) acc_q.push_back(cyc + 1);
    if (rst) acc_q.delete();
    prev_hs    = out_valid && ready && !rst;
    prev_stall = out_valid && !ready && !rst;
    prev_valid = out_valid;
  end

  // Monitor for the 8x8 instance
  logic prev_valid8 = 1'b0;
  always @(negedge clk) begin
    if (out_valid8 && !prev_valid8) begin
      if (exp8_q.size() == 0) fail_now("unexpected_result8");
      else check("result8", int'(p8), exp8_q.pop_front());
      if (acc8_q.size() == 0) fail_now("result8_without_accept");
      else check("latency8", cyc - acc8_q.pop_front(), K_W8);
    end
    if (out_ready8 && in_valid8 && !rst) acc8_q.push_back(cyc + 1);
    if (rst) acc8_q.delete();
    prev_valid8 = out_valid8;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!out_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready) fail_now("timeout_waiting_ready");
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input int av, input int kv, input int cv, input bit push);
    a = IN_W'(av);
    k = K_W'(kv);
    cin = cv[0];
    in_valid = 1'b1;
    wait_ready();
    if (push) exp_q.push_back(av * kv + cv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) fail_now("timeout_draining");
    @(posedge clk);
    #1;
  endtask

  int a_s[3] = '{3, 12, 63};
  int k_s[3] = '{5, 11, 1};
  int c_s[3] = '{0, 1, 0};

  initial begin
    int last;
    int n;

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(out_ready), 1);
    check("reset_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_p", int'(p), 0);
    check("reset_ready8", int'(out_ready8), 1);
    @(posedge clk);
    #1;

    // basic, extreme and zero operands
    ready = 1'b1;
    issue(63, 7, 1, 1'b1);
    drain();
    issue(63, 15, 1, 1'b1);
    issue(0, 15, 1, 1'b1);
    issue(45, 0, 0, 1'b1);
    issue(1, 1, 0, 1'b1);
    issue(32, 8, 1, 1'b1);
    drain();

    // backpressure
    ready = 1'b0;
    issue(10, 9, 0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("timeout_waiting_valid");
    check("busy_in_done", int'(busy), 1);
    check("ready_low_in_done", int'(out_ready), 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    ready = 1'b1;
    drain();

    // i_valid held high with a fresh operand per accept
    last = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = IN_W'(a_s[i]);
      k = K_W'(k_s[i]);
      cin = c_s[i][0];
      wait_ready();
      exp_q.push_back(a_s[i] * k_s[i] + c_s[i]);
      if (i > 0) check("accept_period", cyc - last, K_W + 2);
      last = cyc;
      @(posedge clk);
      #1;
      a = IN_W'(a_s[(i + 1) % 3] + 1);
      k = K_W'(k_s[(i + 1) % 3] + 2);
    end
    in_valid = 1'b0;
    drain();

    // reset during RUN discards the operation
    issue(3, 7, 1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(out_ready), 1);
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_p", int'(p), 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    issue(5, 5, 1, 1'b1);
    drain();

    // 8x8 instance
    ready8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a8 = (i == 0) ? 8'd255 : 8'd1;
      k8 = (i == 0) ? 8'd255 : 8'd128;
      cin8 = (i == 0);
      in_valid8 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!out_ready8 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_ready8) fail_now("timeout_waiting_ready8");
      exp8_q.push_back((i == 0) ? 65026 : 128);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
    end
    n = 0;
    while ((exp8_q.size() != 0 || busy8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp8_q.size() != 0 || busy8) fail_now("timeout_draining8");

    check("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
